sd_debug_viewer: RTL and testbench
==================================

Name: sd_debug_viewer

Overview:
- Parametrised debug-display engine for the SD controller FPGA tops (Nexys4 and the DE-series board).
- Shows one of N debug channels, or one LED-width page of a wide data block (e.g. a 4096-bit sector), on a board LED bus.
- Adds four capabilities the fixed switch-case display mux lacks:
  - snapshotting of the wide block on a valid strobe;
  - freeze;
  - button-stepped paging with wrap;
  - timed auto-scroll.

Parameters:
- LED_WIDTH, 16, width of the LED bus (10 on the DE-series board).
- DATA_WIDTH, 4096, width of the wide data block.
- NUM_CHANNELS, 16, number of debug channels.
- CHANNEL_WIDTH, 16, width of each debug channel.
- SEL_WIDTH, 5, width of the channel-select input.
- SCROLL_PERIOD, 50000000, clock cycles between auto-scroll page advances (minimum 2).
- Derived, not overridable:
  - NUM_PAGES = ceil(DATA_WIDTH/LED_WIDTH).
  - PAGE_BITS = max(1, clog2(NUM_PAGES)).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  wide block source, e.g. read_data.
- data_valid  in  1  one-cycle strobe; data_in is valid this cycle.
- channels  in  NUM_CHANNELS*CHANNEL_WIDTH  packed channels; channel k occupies bits [k*CW +: CW].
- sel  in  SEL_WIDTH  channel index.
- mode  in  2  00 CHANNEL, 01 PAGE, 10 AUTO, 11 HOLD.
- freeze  in  1  level input; 1 blocks snapshot updates.
- step_next  in  1  level input (already debounced); rising edge advances page.
- step_prev  in  1  level input (already debounced); rising edge retreats page.
- led  out  LED_WIDTH  registered display value.
- page_idx  out  PAGE_BITS  current page.
- capture_count  out  8  number of snapshots taken, wraps 255->0.
- stale  out  1  a strobe arrived while frozen.

Behaviour:
- Reset (reset=0, asynchronous): the following are all cleared to 0:
  - led, page_idx, capture_count, stale;
  - snapshot register, scroll timer;
  - edge-detect flops.
- Snapshot:
  - On clock edge with data_valid=1 and freeze=0: snapshot <= data_in, capture_count++, stale <= 0.
  - With data_valid=1 and freeze=1: snapshot is held and stale <= 1.
  - stale clears only on the next accepted capture or on reset.
- Edge detect: step_next and step_prev are each registered once; rise = current & ~previous.
- Page counter, in PAGE and AUTO modes only:
  - next-rise: page_idx+1, wrapping NUM_PAGES-1 -> 0.
  - prev-rise: page_idx-1, wrapping 0 -> NUM_PAGES-1.
  - Both rises in the same cycle: no change.
  - In CHANNEL and HOLD modes, rises are ignored; the edge flops still track the inputs.
- Auto-scroll, AUTO mode only:
  - The timer counts 0..SCROLL_PERIOD-1; at terminal count it returns to 0 and page_idx advances with wrap.
  - A button rise in the same cycle takes priority over the timer and also restarts the timer.
  - The timer is held at 0 in all other modes, and returns to 0 whenever mode changes.
- Display register, updated every cycle:
  - CHANNEL: led <= channels[sel].
    - CHANNEL_WIDTH > LED_WIDTH: the low LED_WIDTH bits are shown.
    - CHANNEL_WIDTH < LED_WIDTH: the value is zero-extended.
    - sel >= NUM_CHANNELS: led <= 0.
  - PAGE and AUTO: led <= snapshot[page_idx*LED_WIDTH +: LED_WIDTH]. Bits beyond DATA_WIDTH on the last page read 0.
  - HOLD: led keeps its value; page_idx and snapshot continue to update.
- Latency:
  - led reflects a sel, mode or page_idx change 1 cycle after the inputs are sampled.
  - led reflects a new capture 2 cycles after the data_valid edge.
- Reset mid-scroll or mid-capture aborts the operation; no partial snapshot is kept.

Decomposition:
- Shared package/header:
  - mode encodings MODE_CHANNEL=2'b00, MODE_PAGE=2'b01, MODE_AUTO=2'b10, MODE_HOLD=2'b11;
  - the ceil-division and clog2 helper functions.
- One natural sub-module: sd_debug_page_counter. It contains:
  - the edge detect;
  - the wrap-around up/down counter;
  - the scroll timer.
  - Parameters: NUM_PAGES, SCROLL_PERIOD.
- Snapshot and display mux stay in the parent.

Test Plan:
- Reset → capture: assert reset=0 with all inputs toggling → led=0, page_idx=0, capture_count=0, stale=0. Release reset, then pulse data_valid with data_in[15:0]=16'hBEEF and mode=PAGE → led=16'hBEEF exactly 2 cycles after the strobe edge; capture_count=1.
- Wrap and simultaneous steps: mode=PAGE, defaults.
  - One step_prev rise from page 0 → page_idx=255 and led=data_in[4095:4080].
  - step_next rise → page_idx=0.
  - Both rises in the same cycle → page_idx unchanged.
- Freeze: freeze=1, strobe data_valid with new data 16'h1234 → led still 16'hBEEF and stale=1. Then freeze=0 and strobe again → led=16'h1234 and stale=0.
- Auto-scroll: SCROLL_PERIOD=4, mode=AUTO.
  - page_idx advances every 4 cycles: 0→1→2.
  - A step_next rise at timer=2 → immediate +1 and timer restart.
  - Switch to PAGE → page_idx frozen.
- Channel view and HOLD: NUM_CHANNELS=16, channel 3=16'h00A5.
  - sel=3 → led=16'h00A5.
  - sel=20 → led=0.
  - Switch to HOLD, then change channels → led stays at its last value.
- Partial last page: LED_WIDTH=10, DATA_WIDTH=4096 → NUM_PAGES=410. Page 409 shows data_in[4095:4090] in led[5:0] and led[9:6]=0; capture_count wraps 255→0 after 256 strobes.

Source files
------------

// File: rtl/sd_debug_viewer_pkg.sv
// Shared mode encodings and elaboration-time sizing helpers for the SD debug viewer.
package sd_debug_viewer_pkg;

    localparam logic [1:0] MODE_CHANNEL = 2'b00;
    localparam logic [1:0] MODE_PAGE    = 2'b01;
    localparam logic [1:0] MODE_AUTO    = 2'b10;
    localparam logic [1:0] MODE_HOLD    = 2'b11;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    // A single page still needs a one-bit index.
    function automatic int unsigned page_bits(input int unsigned num_pages);
        return (num_pages > 1) ? clog2(num_pages) : 1;
    endfunction

endpackage

// File: rtl/sd_debug_page_counter.sv
// Page index with button edge detect, wrap-around stepping and a timed auto-scroll.
module sd_debug_page_counter
    import sd_debug_viewer_pkg::*;
#(
    parameter int unsigned NUM_PAGES     = 256,
    parameter int unsigned SCROLL_PERIOD = 50000000,
    localparam int unsigned PAGE_BITS    = page_bits(NUM_PAGES)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           mode_i,
    input  logic                 step_next_i,
    input  logic                 step_prev_i,
    output logic [PAGE_BITS-1:0] page_idx_o
);

    localparam int unsigned TIMER_BITS = clog2(SCROLL_PERIOD);
    localparam logic [PAGE_BITS-1:0]  LAST_PAGE = PAGE_BITS'(NUM_PAGES - 1);
    localparam logic [TIMER_BITS-1:0] LAST_TICK = TIMER_BITS'(SCROLL_PERIOD - 1);

    logic                  next_q, prev_q;
    logic [PAGE_BITS-1:0]  page_q, page_d, page_inc, page_dec;
    logic [TIMER_BITS-1:0] timer_q, timer_d;
    logic                  rise_next, rise_prev;

    always_comb begin
        rise_next = step_next_i & ~next_q;
        rise_prev = step_prev_i & ~prev_q;
        page_inc  = (page_q == LAST_PAGE) ? '0 : page_q + 1'b1;
        page_dec  = (page_q == '0) ? LAST_PAGE : page_q - 1'b1;
        page_d    = page_q;
        timer_d   = '0;

        if (mode_i == MODE_PAGE || mode_i == MODE_AUTO) begin
            if (rise_next && !rise_prev) begin
                page_d = page_inc;
            end else if (rise_prev && !rise_next) begin
                page_d = page_dec;
            end
        end

        // Any button rise pre-empts the timer and leaves it restarted at 0.
        if (mode_i == MODE_AUTO && !(rise_next || rise_prev)) begin
            if (timer_q == LAST_TICK) begin
                page_d = page_inc;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            next_q  <= 1'b0;
            prev_q  <= 1'b0;
            page_q  <= '0;
            timer_q <= '0;
        end else begin
            next_q  <= step_next_i;
            prev_q  <= step_prev_i;
            page_q  <= page_d;
            timer_q <= timer_d;
        end
    end

    assign page_idx_o = page_q;

endmodule

// File: rtl/sd_debug_viewer.sv
// Debug display engine: channel mux or paged view of a snapshotted wide block onto the LEDs.
module sd_debug_viewer
    import sd_debug_viewer_pkg::*;
#(
    parameter int unsigned LED_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH    = 4096,
    parameter int unsigned NUM_CHANNELS  = 16,
    parameter int unsigned CHANNEL_WIDTH = 16,
    parameter int unsigned SEL_WIDTH     = 5,
    parameter int unsigned SCROLL_PERIOD = 50000000,
    localparam int unsigned NUM_PAGES    = ceil_div(DATA_WIDTH, LED_WIDTH),
    localparam int unsigned PAGE_BITS    = page_bits(NUM_PAGES)
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [DATA_WIDTH-1:0]                   data_in,
    input  logic                                    data_valid,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   channels,
    input  logic [SEL_WIDTH-1:0]                    sel,
    input  logic [1:0]                              mode,
    input  logic                                    freeze,
    input  logic                                    step_next,
    input  logic                                    step_prev,
    output logic [LED_WIDTH-1:0]                    led,
    output logic [PAGE_BITS-1:0]                    page_idx,
    output logic [7:0]                              capture_count,
    output logic                                    stale
);

    localparam int unsigned PAD_WIDTH = NUM_PAGES * LED_WIDTH;

    logic [DATA_WIDTH-1:0]    snap_q, snap_d;
    logic [7:0]               count_q, count_d;
    logic                     stale_q, stale_d;
    logic [LED_WIDTH-1:0]     led_q, led_d;
    logic [PAGE_BITS-1:0]     page_w;
    logic [CHANNEL_WIDTH-1:0] ch_val;
    logic [PAD_WIDTH-1:0]     padded;

    sd_debug_page_counter #(
        .NUM_PAGES     (NUM_PAGES),
        .SCROLL_PERIOD (SCROLL_PERIOD)
    ) u_page_counter (
        .clk_i       (clock),
        .rst_ni      (reset),
        .mode_i      (mode),
        .step_next_i (step_next),
        .step_prev_i (step_prev),
        .page_idx_o  (page_w)
    );

    always_comb begin
        snap_d  = snap_q;
        count_d = count_q;
        stale_d = stale_q;
        if (data_valid) begin
            if (!freeze) begin
                snap_d  = data_in;
                count_d = count_q + 8'd1;
                stale_d = 1'b0;
            end else begin
                stale_d = 1'b1;
            end
        end
    end

    always_comb begin
        // Out-of-range selects match no channel and leave the value at zero.
        ch_val = '0;
        for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
            if (int'(sel) == k) ch_val = channels[k*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        end

        // Zero padding makes the tail of the last page read as 0.
        padded                 = '0;
        padded[DATA_WIDTH-1:0] = snap_q;

        unique case (mode)
            MODE_CHANNEL:         led_d = LED_WIDTH'(ch_val);
            MODE_PAGE, MODE_AUTO: led_d = padded[page_w*LED_WIDTH +: LED_WIDTH];
            default:              led_d = led_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap_q  <= '0;
            count_q <= '0;
            stale_q <= 1'b0;
            led_q   <= '0;
        end else begin
            snap_q  <= snap_d;
            count_q <= count_d;
            stale_q <= stale_d;
            led_q   <= led_d;
        end
    end

    assign led           = led_q;
    assign page_idx      = page_w;
    assign capture_count = count_q;
    assign stale         = stale_q;

endmodule

// File: tb/tb_sd_debug_viewer.sv
// Directed bench: a 16-LED and a 10-LED viewer share stimulus; short scroll period for speed.
module tb_sd_debug_viewer;

    logic          clock = 1'b0;
    logic          reset;
    logic [4095:0] data_in;
    logic          data_valid;
    logic [255:0]  channels;
    logic [4:0]    sel;
    logic [1:0]    mode;
    logic          freeze, step_next, step_prev;

    logic [15:0] led_a;
    logic [7:0]  page_a;
    logic [7:0]  cnt_a;
    logic        stale_a;
    logic [9:0]  led_b;
    logic [8:0]  page_b;
    logic [7:0]  cnt_b;
    logic        stale_b;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    sd_debug_viewer #(
        .LED_WIDTH     (16),
        .DATA_WIDTH    (4096),
        .NUM_CHANNELS  (16),
        .CHANNEL_WIDTH (16),
        .SEL_WIDTH     (5),
        .SCROLL_PERIOD (4)
    ) u_a (
        .clock         (clock),
        .reset         (reset),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .channels      (channels),
        .sel           (sel),
        .mode          (mode),
        .freeze        (freeze),
        .step_next     (step_next),
        .step_prev     (step_prev),
        .led           (led_a),
        .page_idx      (page_a),
        .capture_count (cnt_a),
        .stale         (stale_a)
    );

    sd_debug_viewer #(
        .LED_WIDTH     (10),
        .DATA_WIDTH    (4096),
        .NUM_CHANNELS  (16),
        .CHANNEL_WIDTH (16),
        .SEL_WIDTH     (5),
        .SCROLL_PERIOD (4)
    ) u_b (
        .clock         (clock),
        .reset         (reset),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .channels      (channels),
        .sel           (sel),
        .mode          (mode),
        .freeze        (freeze),
        .step_next     (step_next),
        .step_prev     (step_prev),
        .led           (led_b),
        .page_idx      (page_b),
        .capture_count (cnt_b),
        .stale         (stale_b)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe();
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        data_in    = '0;
        data_valid = 1'b1;
        channels   = '1;
        sel        = 5'd0;
        mode       = 2'b10;
        freeze     = 1'b0;
        step_next  = 1'b0;
        step_prev  = 1'b0;

        // Reset held with inputs toggling.
        for (int i = 0; i < 4; i++) begin
            tick();
            step_next = ~step_next;
            step_prev = ~step_prev;
            mode      = 2'(i);
            data_in   = {128{32'hDEAD_BEEF}};
        end
        check("rst_led_a", 64'(led_a), 64'h0);
        check("rst_page_a", 64'(page_a), 64'h0);
        check("rst_cnt_a", 64'(cnt_a), 64'h0);
        check("rst_stale_a", 64'(stale_a), 64'h0);
        check("rst_led_b", 64'(led_b), 64'h0);

        mode       = 2'b01;
        data_valid = 1'b0;
        step_next  = 1'b0;
        step_prev  = 1'b0;
        data_in    = '0;
        data_in[15:0]      = 16'hBEEF;
        data_in[4095:4080] = 16'hC0DE;
        reset = 1'b1;
        tick();

        // Capture: led updates two edges after the strobe.
        strobe();
        check("cap_led_lat1", 64'(led_a), 64'h0);
        tick();
        check("cap_led_a", 64'(led_a), 64'hBEEF);
        check("cap_cnt", 64'(cnt_a), 64'd1);
        check("cap_stale", 64'(stale_a), 64'h0);
        check("cap_led_b", 64'(led_b), 64'h2EF);

        // Wrap backwards from page 0.
        step_prev = 1'b1;
        tick();
        check("prev_wrap_a", 64'(page_a), 64'd255);
        check("prev_wrap_b", 64'(page_b), 64'd409);
        tick();
        check("last_page_a", 64'(led_a), 64'hC0DE);
        check("last_page_b", 64'(led_b), 64'h030);
        step_prev = 1'b0;
        tick();
        step_next = 1'b1;
        tick();
        check("next_wrap_a", 64'(page_a), 64'd0);
        check("next_wrap_b", 64'(page_b), 64'd0);
        step_next = 1'b0;
        tick();
        step_next = 1'b1;
        tick();
        check("next_inc", 64'(page_a), 64'd1);
        step_next = 1'b0;
        tick();
        step_next = 1'b1;
        step_prev = 1'b1;
        tick();
        check("both_steps", 64'(page_a), 64'd1);
        step_next = 1'b0;
        step_prev = 1'b0;
        tick();
        step_prev = 1'b1;
        tick();
        check("prev_dec", 64'(page_a), 64'd0);
        step_prev = 1'b0;
        tick();

        // Freeze blocks the capture and flags stale.
        freeze = 1'b1;
        data_in[15:0] = 16'h1234;
        strobe();
        tick();
        check("frz_led", 64'(led_a), 64'hBEEF);
        check("frz_stale", 64'(stale_a), 64'h1);
        check("frz_cnt", 64'(cnt_a), 64'd1);
        freeze = 1'b0;
        strobe();
        tick();
        check("unfrz_led", 64'(led_a), 64'h1234);
        check("unfrz_stale", 64'(stale_a), 64'h0);
        check("unfrz_cnt", 64'(cnt_a), 64'd2);

        // Auto-scroll with a period of 4.
        mode = 2'b10;
        repeat (3) tick();
        check("auto_hold0", 64'(page_a), 64'd0);
        tick();
        check("auto_p1", 64'(page_a), 64'd1);
        repeat (4) tick();
        check("auto_p2", 64'(page_a), 64'd2);
        repeat (2) tick();
        step_next = 1'b1;
        tick();
        check("auto_btn", 64'(page_a), 64'd3);
        step_next = 1'b0;
        repeat (3) tick();
        check("auto_restart", 64'(page_a), 64'd3);
        tick();
        check("auto_p4", 64'(page_a), 64'd4);
        mode = 2'b01;
        repeat (8) tick();
        check("page_frozen", 64'(page_a), 64'd4);

        // Channel view and HOLD.
        channels = '0;
        channels[3*16 +: 16] = 16'h00A5;
        mode = 2'b00;
        sel  = 5'd3;
        tick();
        check("ch3_a", 64'(led_a), 64'h00A5);
        check("ch3_b", 64'(led_b), 64'h0A5);
        sel = 5'd20;
        tick();
        check("ch_oob", 64'(led_a), 64'h0);
        sel = 5'd3;
        tick();
        mode = 2'b11;
        tick();
        channels[3*16 +: 16] = 16'hFFFF;
        sel = 5'd5;
        step_next = 1'b1;
        repeat (2) tick();
        check("hold_led", 64'(led_a), 64'h00A5);
        check("hold_page", 64'(page_a), 64'd4);
        step_next = 1'b0;

        // Capture counter wrap: 2 + 253 = 255, one more wraps to 0.
        mode = 2'b01;
        repeat (253) strobe();
        tick();
        check("cnt_255", 64'(cnt_a), 64'd255);
        strobe();
        tick();
        check("cnt_wrap_a", 64'(cnt_a), 64'd0);
        check("cnt_wrap_b", 64'(cnt_b), 64'd0);

        // Reset in the middle of a capture.
        data_in[15:0] = 16'hBEEF;
        data_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("async_rst_cnt", 64'(cnt_a), 64'd0);
        check("async_rst_page", 64'(page_a), 64'd0);
        tick();
        data_valid = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        check("no_partial_snap", 64'(led_a), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
